// File: rtl/fp_exe_seq.sv
// FP execute sequencer: routes tagged ops to single-cycle, FMA or div/sqrt
// paths and gathers completions into a credit-protected response FIFO.
module fp_exe_seq #(
  parameter int FLEN    = 32,
  parameter int TAGW    = 4,
  parameter int DEPTH   = 4,
  parameter int FMA_LAT = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic [TAGW-1:0] req_tag,
  input  logic [FLEN-1:0] sc_result,
  input  logic [4:0]      sc_flags,
  output logic            fma_issue,
  input  logic [FLEN-1:0] fma_result,
  input  logic [4:0]      fma_flags,
  output logic            div_start,
  output logic            div_kill,
  input  logic            div_done,
  input  logic [FLEN-1:0] div_result,
  input  logic [4:0]      div_flags,
  output logic            div_ack,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [TAGW-1:0] rsp_tag,
  output logic [FLEN-1:0] rsp_result,
  output logic [4:0]      rsp_flags
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int UW = $clog2(DEPTH + FMA_LAT + 2) + 1;

  logic [TAGW-1:0] q_tag [DEPTH];
  logic [FLEN-1:0] q_res [DEPTH];
  logic [4:0]      q_flg [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic [FMA_LAT-1:0] fma_v;
  logic [TAGW-1:0]    fma_t [FMA_LAT];

  logic            div_busy;
  logic [TAGW-1:0] div_tag;

  logic [UW-1:0]   used;
  logic            fma_retire, div_take, kind_ok, accept;
  logic            sc_push, push, pop;
  logic [TAGW-1:0] p_tag;
  logic [FLEN-1:0] p_res;
  logic [4:0]      p_flg;

  assign fma_retire = fma_v[FMA_LAT-1];
  // Retiring FMA owns the FIFO write port; a done div waits for it.
  assign div_take   = div_done && div_busy && !fma_retire && !flush;

  // Credits held: queued entries, FMAs in the pipe and an outstanding div.
  always_comb begin
    used = UW'(count) + UW'(div_busy);
    for (int i = 0; i < FMA_LAT; i++)
      used = used + UW'(fma_v[i]);
  end

  // Per-kind acceptance; a single-cycle op needs the free write port.
  always_comb begin
    kind_ok = 1'b0;
    unique case (req_kind)
      2'd0: kind_ok = !fma_retire && !div_take;
      2'd1: kind_ok = 1'b1;
      2'd2: kind_ok = !div_busy;
      2'd3: kind_ok = 1'b0;
    endcase
  end

  assign req_ready = !reset && !flush && (used < UW'(DEPTH)) && kind_ok;
  assign accept    = req_valid && req_ready;
  assign fma_issue = accept && (req_kind == 2'd1);
  assign div_start = accept && (req_kind == 2'd2);
  assign sc_push   = accept && (req_kind == 2'd0);
  assign div_ack   = div_take;
  assign div_kill  = flush && div_busy;

  assign push = !flush && (fma_retire || div_take || sc_push);
  assign pop  = (count != '0) && rsp_ready;

  // Enqueue source select: FMA, then div, then single-cycle.
  always_comb begin
    p_tag = req_tag;
    p_res = sc_result;
    p_flg = sc_flags;
    if (fma_retire) begin
      p_tag = fma_t[FMA_LAT-1];
      p_res = fma_result;
      p_flg = fma_flags;
    end else if (div_take) begin
      p_tag = div_tag;
      p_res = div_result;
      p_flg = div_flags;
    end
  end

  // Response FIFO storage and pointers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_tag[i] <= '0;
        q_res[i] <= '0;
        q_flg[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        q_tag[wr_ptr] <= p_tag;
        q_res[wr_ptr] <= p_res;
        q_flg[wr_ptr] <= p_flg;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FMA tracking shift register: valid bit and tag per stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fma_v <= '0;
      for (int i = 0; i < FMA_LAT; i++)
        fma_t[i] <= '0;
    end else begin
      fma_v[0] <= fma_issue;
      fma_t[0] <= req_tag;
      for (int i = 1; i < FMA_LAT; i++) begin
        fma_v[i] <= fma_v[i-1];
        fma_t[i] <= fma_t[i-1];
      end
      if (flush)
        fma_v <= '0;
    end
  end

  // Single outstanding div/sqrt: busy flag and its tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_busy <= 1'b0;
      div_tag  <= '0;
    end else if (flush) begin
      div_busy <= 1'b0;
    end else if (div_start) begin
      div_busy <= 1'b1;
      div_tag  <= req_tag;
    end else if (div_take) begin
      div_busy <= 1'b0;
    end
  end

  assign rsp_valid  = (count != '0);
  assign rsp_tag    = q_tag[rd_ptr];
  assign rsp_result = q_res[rd_ptr];
  assign rsp_flags  = q_flg[rd_ptr];

endmodule

// File: tb/tb_fp_exe_seq.sv
// Bench for fp_exe_seq: vector table plus cycle-exact sequences, with a
// tag-matched scoreboard on every response.
module tb_fp_exe_seq;

  localparam int FLEN    = 32;
  localparam int TAGW    = 4;
  localparam int DEPTH   = 4;
  localparam int FMA_LAT = 3;

  logic        clock = 1'b0;
  logic        reset, flush, req_valid, req_ready;
  logic [1:0]  req_kind;
  logic [3:0]  req_tag;
  logic [31:0] sc_result;
  logic [4:0]  sc_flags;
  logic        fma_issue;
  logic [31:0] fma_result;
  logic [4:0]  fma_flags;
  logic        div_start, div_kill, div_done, div_ack;
  logic [31:0] div_result;
  logic [4:0]  div_flags;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idx;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [1:0] kind;
    logic [3:0] tag;
    logic       rdy;
  } vec_t;
  vec_t tbl[9];

  fp_exe_seq #(
    .FLEN(FLEN), .TAGW(TAGW), .DEPTH(DEPTH), .FMA_LAT(FMA_LAT)
  ) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .req_tag(req_tag),
    .sc_result(sc_result), .sc_flags(sc_flags),
    .fma_issue(fma_issue), .fma_result(fma_result),
    .fma_flags(fma_flags),
    .div_start(div_start), .div_kill(div_kill),
    .div_done(div_done), .div_result(div_result),
    .div_flags(div_flags), .div_ack(div_ack),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_tag(rsp_tag), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] fma_val(input int c);
    return {16'hFA00, c[15:0]};
  endfunction
  function automatic logic [4:0] fma_flg(input int c);
    return c[4:0] ^ 5'h0A;
  endfunction
  function automatic logic [31:0] div_val(input logic [3:0] t);
    return {28'hD1D0000, t};
  endfunction
  function automatic logic [4:0] div_flg(input logic [3:0] t);
    return {1'b1, t};
  endfunction

  // FMA model: result is a function of the cycle it is sampled in
  assign fma_result = fma_val(cyc);
  assign fma_flags  = fma_flg(cyc);

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] k,
                       input logic [3:0] t);
    req_valid = v;
    req_kind  = k;
    req_tag   = t;
    sc_result = {28'h5C00000, t};
    sc_flags  = {1'b0, t} ^ 5'h15;
  endtask

  task automatic nxt;
    @(posedge clock);
    #1;
  endtask

  task automatic smp;
    @(negedge clock);
  endtask

  task automatic drain;
    for (int i = 0; i < 30; i++) begin
      smp();
      if (!rsp_valid && sbq.size() == 0) break;
      nxt();
    end
    chk("drain_empty", 64'(sbq.size()), 0);
    nxt();
  endtask

  // Scoreboard: push on accept, tag-matched compare on pop
  always @(negedge clock) begin
    if (!reset) begin
      if (flush) begin
        sbq.delete();
      end else begin
        if (rsp_valid && rsp_ready) begin
          idx = -1;
          for (int i = 0; i < sbq.size(); i++)
            if (idx < 0 && sbq[i].tag == rsp_tag) idx = i;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got tag %0h, required none",
                     rsp_tag);
          end else begin
            if (rsp_result !== sbq[idx].res || rsp_flags !== sbq[idx].flg) begin
              errors++;
              $display("FAIL rsp_data tag %0h: got %0h/%0h required %0h/%0h",
                       rsp_tag, rsp_result, rsp_flags,
                       sbq[idx].res, sbq[idx].flg);
            end
            sbq.delete(idx);
          end
        end
        if (req_valid && req_ready) begin
          case (req_kind)
            2'd0: sbq.push_back('{req_tag, sc_result, sc_flags});
            2'd1: sbq.push_back('{req_tag, fma_val(cyc + FMA_LAT),
                                  fma_flg(cyc + FMA_LAT)});
            2'd2: sbq.push_back('{req_tag, div_val(req_tag),
                                  div_flg(req_tag)});
            default: ;
          endcase
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{2'd0, 4'd0, 1'b1};
    tbl[1] = '{2'd0, 4'd1, 1'b1};
    tbl[2] = '{2'd3, 4'd2, 1'b0};
    tbl[3] = '{2'd1, 4'd3, 1'b1};
    tbl[4] = '{2'd0, 4'd4, 1'b1};
    tbl[5] = '{2'd2, 4'd5, 1'b1};
    tbl[6] = '{2'd0, 4'd6, 1'b0};
    tbl[7] = '{2'd2, 4'd7, 1'b0};
    tbl[8] = '{2'd0, 4'd8, 1'b1};

    reset = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
    div_done = 1'b0; div_result = '0; div_flags = '0;
    drive(1'b1, 2'd1, 4'd0);
    repeat (2) smp();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fma_issue", fma_issue, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_div_ack", div_ack, 0);
    chk("rst_div_kill", div_kill, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    nxt();
    reset = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b0, 2'd0, 4'd0);
    nxt();

    // back-to-back single-cycle ops
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'd0, 4'(k));
      smp();
      chk("b2b_ready", req_ready, 1);
      chk("b2b_valid", rsp_valid, k > 0);
      if (k > 0) chk("b2b_tag", rsp_tag, k - 1);
      nxt();
    end
    drive(1'b0, 2'd0, 4'd0);
    smp();
    chk("b2b_last_tag", rsp_tag, 3);
    nxt();
    drain();

    // vector table
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, tbl[i].kind, tbl[i].tag);
      smp();
      chk("tbl_ready", req_ready, tbl[i].rdy);
      chk("tbl_fma_issue", fma_issue, tbl[i].kind == 2'd1 && tbl[i].rdy);
      chk("tbl_div_start", div_start, tbl[i].kind == 2'd2 && tbl[i].rdy);
      nxt();
    end
    drive(1'b0, 2'd0, 4'd0);
    div_done = 1'b1; div_result = div_val(4'd5); div_flags = div_flg(4'd5);
    smp();
    chk("tbl_div_ack", div_ack, 1);
    nxt();
    div_done = 1'b0;
    drain();

    // FMA pipelining
    drive(1'b1, 2'd1, 4'd5);
    smp(); chk("fma_issue0", fma_issue, 1); nxt();
    drive(1'b1, 2'd1, 4'd6);
    smp(); chk("fma_issue1", fma_issue, 1); nxt();
    drive(1'b0, 2'd0, 4'd0);
    smp(); chk("fma_c2_valid", rsp_valid, 0); nxt();
    smp(); chk("fma_c3_valid", rsp_valid, 0); nxt();
    smp(); chk("fma_c4_valid", rsp_valid, 1);
    chk("fma_c4_tag", rsp_tag, 5); nxt();
    smp(); chk("fma_c5_tag", rsp_tag, 6); nxt();
    drain();

    // collision: FMA retire vs div_done vs single-cycle request
    drive(1'b1, 2'd1, 4'd7);
    smp(); chk("col_fma_issue", fma_issue, 1); nxt();
    drive(1'b1, 2'd2, 4'd8);
    smp(); chk("col_div_start", div_start, 1); nxt();
    drive(1'b0, 2'd0, 4'd0);
    smp(); nxt();
    drive(1'b1, 2'd0, 4'd9);
    div_done = 1'b1; div_result = div_val(4'd8); div_flags = div_flg(4'd8);
    smp();
    chk("col_div_ack0", div_ack, 0);
    chk("col_req_ready0", req_ready, 0);
    nxt();
    smp();
    chk("col_div_ack1", div_ack, 1);
    chk("col_rsp_tag7", rsp_tag, 7);
    nxt();
    div_done = 1'b0;
    smp();
    chk("col_req_ready2", req_ready, 1);
    chk("col_rsp_tag8", rsp_tag, 8);
    nxt();
    drive(1'b0, 2'd0, 4'd0);
    smp(); chk("col_rsp_tag9", rsp_tag, 9); nxt();
    drain();

    // credit full
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'd0, 4'(k + 1));
      smp(); chk("cr_ready", req_ready, 1); nxt();
    end
    drive(1'b1, 2'd0, 4'd5);
    smp(); chk("cr_full", req_ready, 0); nxt();
    rsp_ready = 1'b1;
    smp();
    chk("cr_no_bypass", req_ready, 0);
    chk("cr_head", rsp_tag, 1);
    nxt();
    rsp_ready = 1'b0;
    smp(); chk("cr_one_more", req_ready, 1); nxt();
    drive(1'b1, 2'd0, 4'd6);
    smp(); chk("cr_full_again", req_ready, 0); nxt();
    drive(1'b0, 2'd0, 4'd0);
    rsp_ready = 1'b1;
    drain();

    // div busy
    drive(1'b1, 2'd2, 4'd3);
    smp();
    chk("db_ready0", req_ready, 1);
    chk("db_start0", div_start, 1);
    nxt();
    drive(1'b1, 2'd2, 4'd4);
    smp();
    chk("db_busy1", req_ready, 0);
    chk("db_nostart", div_start, 0);
    nxt();
    smp(); chk("db_busy2", req_ready, 0); nxt();
    div_done = 1'b1; div_result = div_val(4'd3); div_flags = div_flg(4'd3);
    smp();
    chk("db_ack", div_ack, 1);
    chk("db_busy_ack", req_ready, 0);
    nxt();
    div_done = 1'b0;
    smp();
    chk("db_ready_after", req_ready, 1);
    chk("db_start2", div_start, 1);
    chk("db_rsp_tag3", rsp_tag, 3);
    nxt();
    drive(1'b0, 2'd0, 4'd0);
    smp(); nxt();
    div_done = 1'b1; div_result = div_val(4'd4); div_flags = div_flg(4'd4);
    smp(); chk("db_ack2", div_ack, 1); nxt();
    div_done = 1'b0;
    smp(); chk("db_rsp_tag4", rsp_tag, 4); nxt();
    drain();

    // flush mid-flight
    rsp_ready = 1'b0;
    drive(1'b1, 2'd0, 4'd1); smp(); nxt();
    drive(1'b1, 2'd0, 4'd2); smp(); nxt();
    drive(1'b1, 2'd2, 4'd3);
    smp(); chk("fl_div_start", div_start, 1); nxt();
    drive(1'b1, 2'd1, 4'd4);
    smp(); chk("fl_fma_issue", fma_issue, 1); nxt();
    drive(1'b1, 2'd1, 4'd5);
    flush = 1'b1;
    div_done = 1'b1; div_result = div_val(4'd3); div_flags = div_flg(4'd3);
    smp();
    chk("fl_div_kill", div_kill, 1);
    chk("fl_req_ready", req_ready, 0);
    chk("fl_fma_issue0", fma_issue, 0);
    chk("fl_div_ack", div_ack, 0);
    chk("fl_rsp_valid_pre", rsp_valid, 1);
    nxt();
    flush = 1'b0;
    div_done = 1'b0;
    drive(1'b0, 2'd0, 4'd0);
    rsp_ready = 1'b1;
    smp();
    chk("fl_rsp_valid", rsp_valid, 0);
    chk("fl_div_kill_off", div_kill, 0);
    nxt();
    for (int k = 0; k < 4; k++) begin
      smp(); chk("fl_no_late_rsp", rsp_valid, 0); nxt();
    end
    chk("fl_sb_empty", 64'(sbq.size()), 0);
    drive(1'b1, 2'd0, 4'hA);
    smp(); chk("fl_recover_ready", req_ready, 1); nxt();
    drive(1'b0, 2'd0, 4'd0);
    smp();
    chk("fl_recover_valid", rsp_valid, 1);
    chk("fl_recover_tag", rsp_tag, 4'hA);
    nxt();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
